// File: rtl/gmux_pkg.sv
// Shared definitions for the gmux selector family: select width, way count and named select codes.
package gmux_pkg;

    localparam int unsigned SEL_W  = 3;
    localparam int unsigned N_WAYS = 8;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t SEL_A = 3'd0;
    localparam sel_t SEL_B = 3'd1;
    localparam sel_t SEL_C = 3'd2;
    localparam sel_t SEL_D = 3'd3;
    localparam sel_t SEL_E = 3'd4;
    localparam sel_t SEL_F = 3'd5;
    localparam sel_t SEL_G = 3'd6;
    localparam sel_t SEL_H = 3'd7;

endpackage

// File: rtl/gmux_2way_16.sv
// Two-input word selector used as the leaf cell of the 8-way tree: out = sel ? b : a.
module gmux_2way_16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    assign out = sel ? b : a;

endmodule

// File: rtl/gmux_8way_16.sv
// 8-input word selector built as a 3-level tree of 2-way muxes, plus a registered copy of the result.
// Optional parity outputs (out_par, out_par_q) are enabled by defining GMUX_8WAY_16_PARITY_EN.
module gmux_8way_16
    import gmux_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] h,
    input  logic [SEL_W-1:0] sel,
`ifdef GMUX_8WAY_16_PARITY_EN
    output logic             out_par,
    output logic             out_par_q,
`endif
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q
);

    logic [WIDTH-1:0] l1_ab, l1_cd, l1_ef, l1_gh;
    logic [WIDTH-1:0] l2_ad, l2_eh;
    logic [WIDTH-1:0] out_d;

    // Level 1: sel[0] picks within each adjacent pair.
    gmux_2way_16 #(.WIDTH(WIDTH)) u_l1_ab (.a(a), .b(b), .sel(sel[0]), .out(l1_ab));
    gmux_2way_16 #(.WIDTH(WIDTH)) u_l1_cd (.a(c), .b(d), .sel(sel[0]), .out(l1_cd));
    gmux_2way_16 #(.WIDTH(WIDTH)) u_l1_ef (.a(e), .b(f), .sel(sel[0]), .out(l1_ef));
    gmux_2way_16 #(.WIDTH(WIDTH)) u_l1_gh (.a(g), .b(h), .sel(sel[0]), .out(l1_gh));

    gmux_2way_16 #(.WIDTH(WIDTH)) u_l2_ad (.a(l1_ab), .b(l1_cd), .sel(sel[1]), .out(l2_ad));
    gmux_2way_16 #(.WIDTH(WIDTH)) u_l2_eh (.a(l1_ef), .b(l1_gh), .sel(sel[1]), .out(l2_eh));

    gmux_2way_16 #(.WIDTH(WIDTH)) u_l3 (.a(l2_ad), .b(l2_eh), .sel(sel[2]), .out(out));

`ifdef GMUX_8WAY_16_PARITY_EN
    logic out_par_d;

    always_comb begin
        out_d     = out;
        out_par   = ^out;
        out_par_d = out_par;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q     <= '0;
            out_par_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            out_par_q <= out_par_d;
        end
    end
`else
    always_comb begin
        out_d = out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end
`endif

endmodule

// File: tb/tb_gmux_8way_16.sv
// Directed and random bench for gmux_8way_16; expected words flow through a scoreboard queue.
// Define GMUX_8WAY_16_PARITY_EN to also exercise the parity outputs.
module tb_gmux_8way_16;
    import gmux_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a, b, c, d, e, f, g, h;
    logic [2:0]  sel;
    logic [15:0] out, out_q;
`ifdef GMUX_8WAY_16_PARITY_EN
    logic        out_par, out_par_q;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [15:0] sb_q[$];
    logic [15:0] words [N_WAYS];
    logic [15:0] expv;

    gmux_8way_16 #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .e     (e),
        .f     (f),
        .g     (g),
        .h     (h),
        .sel   (sel),
`ifdef GMUX_8WAY_16_PARITY_EN
        .out_par   (out_par),
        .out_par_q (out_par_q),
`endif
        .out   (out),
        .out_q (out_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_words();
        a = words[0]; b = words[1]; c = words[2]; d = words[3];
        e = words[4]; f = words[5]; g = words[6]; h = words[7];
    endtask

    // Reference: plain array index, independent of the tree structure.
    function automatic logic [15:0] ref_sel(input logic [2:0] s);
        return words[s];
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++) words[i] = 16'h1111 * 16'(i + 1);
        drive_words();
        sel = SEL_A;
        #1;
        check("reset_no_clk", out_q, 16'h0000);

        // Sweep all codes while reset holds out_q at zero.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sel = sel_t'(i);
            sb_q.push_back(16'h1111 * 16'(i + 1));
            #1;
            expv = sb_q.pop_front();
            check($sformatf("sweep_out_%0d", i), out, expv);
            check($sformatf("sweep_rst_q_%0d", i), out_q, 16'h0000);
        end

        @(negedge clk);
        sel = SEL_F;
        #1;
        f = 16'hBEEF;
        words[5] = 16'hBEEF;
        #1;
        check("comb_beef", out, 16'hBEEF);
        check("comb_rst_q", out_q, 16'h0000);

        @(negedge clk);
        rst = 1'b0;
        sel = SEL_D;
        d = 16'hCAFE;
        words[3] = 16'hCAFE;
        sb_q.push_back(16'hCAFE);
        @(posedge clk);
        #1;
        expv = sb_q.pop_front();
        check("reg_first_edge", out_q, expv);

        #2;
        rst = 1'b1;
        #1;
        check("async_rst_q", out_q, 16'h0000);
        check("async_rst_out", out, 16'hCAFE);
        @(negedge clk);
        rst = 1'b0;

`ifdef GMUX_8WAY_16_PARITY_EN
        @(negedge clk);
        sel = SEL_A;
        a = 16'h0007;
        #1;
        check("par_0007", {15'd0, out_par}, 16'd1);
        @(posedge clk);
        #1;
        check("par_q_0007", {15'd0, out_par_q}, 16'd1);
        @(negedge clk);
        a = 16'h0003;
        #1;
        check("par_0003", {15'd0, out_par}, 16'd0);
        @(posedge clk);
        #1;
        check("par_q_0003", {15'd0, out_par_q}, 16'd0);
`endif

        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) words[i] = 16'($urandom);
            drive_words();
            sel = 3'($urandom_range(7, 0));
            expv = ref_sel(sel);
            sb_q.push_back(expv);
            #1;
            check($sformatf("rand_out_%0d", n), out, expv);
`ifdef GMUX_8WAY_16_PARITY_EN
            check($sformatf("rand_par_%0d", n), {15'd0, out_par}, {15'd0, ^expv});
`endif
            @(posedge clk);
            #1;
            expv = sb_q.pop_front();
            check($sformatf("rand_q_%0d", n), out_q, expv);
        end

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL sb_empty: observed %0d expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
